// File: rtl/hex_scan_controller.sv
// Multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-anode
// digits, with a dark guard at the start of every slot and double-buffered values.
module hex_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 8,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  output logic [3:0]                nibble,
  input  logic [6:0]                seg_in,
  output logic [6:0]                seg_out,
  output logic [NUM_DIGITS-1:0]     digit_en_n,
  output logic                      frame_done
);

  localparam int unsigned SHOW_CYCLES = SCAN_DIV - BLANK_CYCLES;
  localparam int unsigned CNT_W       = $clog2(SCAN_DIV);
  localparam int unsigned DIG_W       = $clog2(NUM_DIGITS);
  localparam int unsigned VAL_W       = 4 * NUM_DIGITS;
  localparam logic [6:0]  SEG_DARK    = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [VAL_W-1:0]        pending_q, pending_d;
  logic [VAL_W-1:0]        active_q, active_d;
  logic [6:0]              seg_out_q, seg_out_d;
  logic [NUM_DIGITS-1:0]   digit_en_n_q, digit_en_n_d;
  logic                    frame_done_q, frame_done_d;

  logic                    blank_end;
  logic                    show_end;
  logic                    last_digit;
  logic                    digit_dark;

  assign blank_end  = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
  assign show_end   = (cnt_q == CNT_W'(SHOW_CYCLES - 1));
  assign last_digit = (digit_q == DIG_W'(NUM_DIGITS - 1));
  assign digit_dark = blank_mask[digit_q];

  // Decoder feed: select the active nibble of the digit currently being scanned.
  always_comb begin
    nibble = 4'h0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (digit_q == DIG_W'(k)) begin
        nibble = active_q[4*k +: 4];
      end
    end
  end

  // Next-state, buffering and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    pending_d    = load ? value_in : pending_q;
    active_d     = active_q;
    seg_out_d    = SEG_DARK;
    digit_en_n_d = '1;
    frame_done_d = 1'b0;

    if (enable) begin
      case (state_q)
        ST_BLANK: begin
          if (blank_end) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_SHOW: begin
          if (!digit_dark) begin
            seg_out_d    = seg_in;
            digit_en_n_d = ~(NUM_DIGITS'(1) << digit_q);
          end
          if (show_end) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (last_digit) begin
              // Wrap edge: commit so the new frame starts with coherent data.
              digit_d      = '0;
              frame_done_d = 1'b1;
              active_d     = pending_d;
            end else begin
              digit_d = digit_q + DIG_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      digit_q      <= '0;
      pending_q    <= '0;
      active_q     <= '0;
      seg_out_q    <= SEG_DARK;
      digit_en_n_q <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      seg_out_q    <= seg_out_d;
      digit_en_n_q <= digit_en_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_out_q;
  assign digit_en_n = digit_en_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_controller.sv
// Bench for hex_scan_controller: flat frame-phase reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_hex_scan_controller;

  localparam int unsigned ND    = 4;
  localparam int unsigned SD    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  blank_mask;
  logic [3:0]  nibble;
  logic [6:0]  seg_in;
  logic [6:0]  seg_out;
  logic [3:0]  digit_en_n;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  hex_scan_controller #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .value_in  (value_in),
    .blank_mask(blank_mask),
    .nibble    (nibble),
    .seg_in    (seg_in),
    .seg_out   (seg_out),
    .digit_en_n(digit_en_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference hex decoder, active-low, bit0 = segment a.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  assign seg_in = hex7(nibble);

  function automatic int unsigned dig_of(input int unsigned p);
    return p / SD;
  endfunction

  function automatic bit shows(input int unsigned p);
    return (p % SD) >= BC;
  endfunction

  // Model: a single phase counter 0..FRAME-1 that advances while enabled.
  int unsigned m_phase;
  logic [15:0] m_pending, m_active;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_en;
  logic        exp_fd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   <= 0;
      m_pending <= '0;
      m_active  <= '0;
      exp_seg   <= 7'h7F;
      exp_en    <= 4'hF;
      exp_fd    <= 1'b0;
    end else begin
      if (enable && shows(m_phase) && !blank_mask[dig_of(m_phase)]) begin
        exp_seg <= hex7(m_active[4*dig_of(m_phase) +: 4]);
        exp_en  <= ~(4'b0001 << dig_of(m_phase));
      end else begin
        exp_seg <= 7'h7F;
        exp_en  <= 4'hF;
      end
      exp_fd <= enable && (m_phase == FRAME - 1);
      if (enable) m_phase <= (m_phase + 1) % FRAME;
      if (load) m_pending <= value_in;
      if (enable && (m_phase == FRAME - 1)) m_active <= load ? value_in : m_pending;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_on) begin
      chk("seg_out", 32'(seg_out), 32'(exp_seg));
      chk("digit_en_n", 32'(digit_en_n), 32'(exp_en));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      chk("nibble", 32'(nibble), 32'(m_active[4*dig_of(m_phase) +: 4]));
    end
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    if (frame_done !== 1'b1) chk("frame_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic chk_out(input string nm, input logic [6:0] s, input logic [3:0] e);
    chk({nm, "_seg"}, 32'(seg_out), 32'(s));
    chk({nm, "_en"}, 32'(digit_en_n), 32'(e));
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    load       = 1'b0;
    value_in   = '0;
    blank_mask = '0;
    adv(3);
    chk_out("reset", 7'h7F, 4'hF);
    chk("reset_fd", 32'(frame_done), 32'd0);
    rst_n  = 1'b1;
    cmp_on = 1'b1;

    // Scan order: 16'h1234 appears in the frame after the first wrap.
    enable   = 1'b1;
    load     = 1'b1;
    value_in = 16'h1234;
    adv(1);
    load = 1'b0;
    wait_frame();
    adv(2);  chk_out("guard_dark", 7'h7F, 4'hF);
    adv(1);  chk_out("d0_four", 7'h19, 4'hE);
    adv(24); chk_out("d3_one", 7'h79, 4'h7);
    adv(5);
    chk("frame_period", 32'(frame_done), 32'd1);
    chk_out("d3_last", 7'h79, 4'h7);

    // Tear-free: load mid-frame does not disturb digits 2 and 3.
    adv(10);
    load     = 1'b1;
    value_in = 16'hABCD;
    adv(1);
    load = 1'b0;
    adv(8);  chk_out("tear_d2", 7'h24, 4'hB);
    adv(8);  chk_out("tear_d3", 7'h79, 4'h7);
    adv(5);  chk("tear_fd", 32'(frame_done), 32'd1);
    adv(3);  chk_out("new_d0", 7'h21, 4'hE);
    adv(24); chk_out("new_d3", 7'h08, 4'h7);
    adv(5);

    // Load on the wrap edge goes straight into the next frame.
    adv(31);
    load     = 1'b1;
    value_in = 16'h00F0;
    adv(1);
    load = 1'b0;
    chk("wrap_fd", 32'(frame_done), 32'd1);
    adv(3);  chk_out("wrap_d0", 7'h40, 4'hE);
    adv(8);  chk_out("wrap_d1", 7'h0E, 4'hD);

    // Masked digit 2 and a 5-cycle enable gap during digit 3's SHOW.
    blank_mask = 4'b0100;
    adv(8);  chk_out("mask_d2", 7'h7F, 4'hF);
    adv(9);
    enable = 1'b0;
    adv(1);  chk_out("disabled", 7'h7F, 4'hF);
    adv(3);  chk("frozen_fd", 32'(frame_done), 32'd0);
    adv(1);
    enable = 1'b1;
    adv(1);  chk_out("resume_d3", 7'h40, 4'h7);
    adv(3);  chk("resume_fd", 32'(frame_done), 32'd1);

    // Asynchronous reset mid-SHOW takes effect without a clock edge.
    adv(4);  chk_out("pre_reset", 7'h40, 4'hE);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 7'h7F, 4'hF);
    chk("async_rst_fd", 32'(frame_done), 32'd0);
    chk("async_rst_nib", 32'(nibble), 32'd0);
    adv(2);
    rst_n      = 1'b1;
    blank_mask = '0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 7) != 0);
      load     = ($urandom_range(0, 5) == 0);
      value_in = 16'($urandom);
      if ($urandom_range(0, 49) == 0) blank_mask = 4'($urandom_range(0, 15));
      if (i % 1000 == 500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      adv(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
